// File: rtl/csa_pipe_adder.sv
// csa_pipe_adder: pipelined carry-select adder/subtractor.
// An input rank captures the operands, then each of the WIDTH/SEG stages
// resolves one SEG-bit segment. A stage forms both possible segment sums
// (carry-in 0 and 1) and selects one with the carry registered by the
// previous stage. Unconsumed operand bits and finished sum bits travel
// alongside the carry in per-stage skew registers.
// WIDTH must be a multiple of SEG and at least 8.
//
// Handshake: a bundle moves on a rising edge where valid and ready are both 1.
// Ready must not depend on valid, and a producer holds its bundle stable
// until it is taken. Here the whole pipe advances when
// adv = out_ready | ~out_valid, and in_ready is adv itself.
module csa_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             CarryOut,
    output logic             Overflow
);

    localparam int STAGES = WIDTH / SEG;

    // Rank 0 is the input capture; rank k+1 holds the result of stage k.
    logic             vldR [0:STAGES];
    logic             cR   [0:STAGES];
    logic [WIDTH-1:0] sR   [0:STAGES];
    logic [WIDTH-1:0] aR   [0:STAGES-1];
    logic [WIDTH-1:0] bR   [0:STAGES-1];
    logic             ovfR;

    logic             adv;
    logic [SEG-1:0]   aSeg;
    logic [SEG-1:0]   bSeg;
    logic [SEG:0]     sum0;
    logic [SEG:0]     sum1;
    logic [SEG:0]     segSel;
    logic [WIDTH-1:0] nxtSum   [0:STAGES-1];
    logic             nxtCarry [0:STAGES-1];
    logic             nxtOvf;

    assign adv       = out_ready | ~vldR[STAGES];
    assign in_ready  = adv;
    assign out_valid = vldR[STAGES];
    assign Sum       = sR[STAGES];
    assign CarryOut  = cR[STAGES];
    assign Overflow  = ovfR;

    // Per-stage carry-select: two segment sums, picked by the incoming carry.
    always_comb begin
        aSeg   = '0;
        bSeg   = '0;
        sum0   = '0;
        sum1   = '0;
        segSel = '0;
        for (int k = 0; k < STAGES; k++) begin
            aSeg        = aR[k][k*SEG +: SEG];
            bSeg        = bR[k][k*SEG +: SEG];
            sum0        = {1'b0, aSeg} + {1'b0, bSeg};
            sum1        = sum0 + {{SEG{1'b0}}, 1'b1};
            segSel      = cR[k] ? sum1 : sum0;
            nxtSum[k]   = sR[k];
            nxtSum[k][k*SEG +: SEG] = segSel[SEG-1:0];
            nxtCarry[k] = segSel[SEG];
        end
        // Signed overflow: operand MSBs agree but the sum MSB differs.
        nxtOvf = (aR[STAGES-1][WIDTH-1] == bR[STAGES-1][WIDTH-1]) &&
                 (nxtSum[STAGES-1][WIDTH-1] != aR[STAGES-1][WIDTH-1]);
    end

    // Whole pipe shifts one rank on adv, holds otherwise; reset empties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= STAGES; k++) begin
                vldR[k] <= 1'b0;
                cR[k]   <= 1'b0;
                sR[k]   <= '0;
            end
            for (int k = 0; k < STAGES; k++) begin
                aR[k] <= '0;
                bR[k] <= '0;
            end
            ovfR <= 1'b0;
        end else if (adv) begin
            // Subtraction is A + ~B + 1, so the carry-in is forced high.
            vldR[0] <= in_valid;
            aR[0]   <= A;
            bR[0]   <= sub ? ~B : B;
            cR[0]   <= sub | cin;
            sR[0]   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                vldR[k+1] <= vldR[k];
                sR[k+1]   <= nxtSum[k];
                cR[k+1]   <= nxtCarry[k];
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                aR[k+1] <= aR[k];
                bR[k+1] <= bR[k];
            end
            ovfR <= nxtOvf;
        end
    end

endmodule
